// File: rtl/mem_access_unit_if.sv
// mem_access_unit_if: handshaked data-memory bus between the load/store unit
// (master) and a data cache or AXI bridge (slave).
//   data_req_o     master->slave  request valid, held until data_addr_ok_i
//   data_wr_o      master->slave  1 = write
//   data_wstrb_o   master->slave  byte strobes, bit 3 = byte offset 0
//   data_addr_o    master->slave  word-aligned address
//   data_wdata_o   master->slave  write data (lane-replicated)
//   data_addr_ok_i slave->master  request accepted
//   data_data_ok_i slave->master  read data valid / write acknowledged
//   data_rdata_i   slave->master  read data
interface mem_access_unit_if #(
    parameter int ADDR_WIDTH = 32
);
    logic                  data_req_o;
    logic                  data_wr_o;
    logic [3:0]            data_wstrb_o;
    logic [ADDR_WIDTH-1:0] data_addr_o;
    logic [31:0]           data_wdata_o;
    logic                  data_addr_ok_i;
    logic                  data_data_ok_i;
    logic [31:0]           data_rdata_i;

    modport master (
        output data_req_o, data_wr_o, data_wstrb_o, data_addr_o, data_wdata_o,
        input  data_addr_ok_i, data_data_ok_i, data_rdata_i
    );

    modport slave (
        input  data_req_o, data_wr_o, data_wstrb_o, data_addr_o, data_wdata_o,
        output data_addr_ok_i, data_data_ok_i, data_rdata_i
    );
endinterface

// File: rtl/mem_access_unit.sv
// mem_access_unit: multi-cycle load/store unit for the memory stage.
// Accepts one op at a time from the pipeline, steers bytes onto a
// req/addr_ok/data_ok bus, sign/zero-extends loads, flags misaligned
// accesses (ALE), handles LL/SC, pipeline flushes and a bus watchdog.
//
// Optional feature: define MEM_LLSC_EN to build the LLbit, the SC-fail path
// and llbit_clr_i handling. Without it LL is a plain word load and SC always
// stores and reports success.
//
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   mem_*_i, tag_i      op presented by the pipeline (valid/ready handshake)
//   ready_o, busy_o     unit idle / unit busy
//   flush_i             pipeline flush, llbit_clr_i clears LLbit (ERTN)
//   done_o ... bad_addr_o  one-cycle completion pulse and its payload
//   bus                 data bus, master side (all bus outputs registered)
module mem_access_unit #(
    parameter int ADDR_WIDTH     = 32,
    parameter int TAG_WIDTH      = 5,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  mem_valid_i,
    output logic                  ready_o,
    input  logic                  mem_we_i,
    input  logic [1:0]            mem_size_i,
    input  logic                  mem_unsigned_i,
    input  logic                  mem_ll_i,
    input  logic                  mem_sc_i,
    input  logic [ADDR_WIDTH-1:0] mem_addr_i,
    input  logic [31:0]           store_data_i,
    input  logic [TAG_WIDTH-1:0]  tag_i,
    input  logic                  flush_i,
    input  logic                  llbit_clr_i,
    output logic                  done_o,
    output logic [31:0]           rdata_o,
    output logic [TAG_WIDTH-1:0]  tag_o,
    output logic                  ale_o,
    output logic                  buserr_o,
    output logic [ADDR_WIDTH-1:0] bad_addr_o,
    output logic                  busy_o,
    mem_access_unit_if.master     bus
);
    typedef enum logic [1:0] {IDLE, REQ, WAIT, DRAIN} state_t;

    typedef struct packed {
        logic                  we;
        logic [1:0]            size;
        logic                  uns;
        logic                  ll;
        logic                  sc;
        logic [ADDR_WIDTH-1:0] addr;
        logic [TAG_WIDTH-1:0]  tag;
    } op_t;

    localparam int CW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [CW-1:0] TO_LAST = CW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

    state_t                state, state_nxt;
    op_t                   op;
    logic [CW-1:0]         cnt;
    logic                  accept, ale, sc_fail, go_bus, fast, timeout, data_ok, kill;
    logic [1:0]            off, size_eff;
    logic [3:0]            strb_d;
    logic [31:0]           wdata_d, load_val;
    logic [7:0]            byte_v;
    logic [15:0]           half_v;
    logic                  done_d, ale_d, buserr_d, fast_d;
    logic [31:0]           rdata_d;
    logic [TAG_WIDTH-1:0]  tag_d;
    logic [ADDR_WIDTH-1:0] bad_d;
    logic                  done_q, ale_q, fast_q;

    assign ready_o  = (state == IDLE);
    assign busy_o   = ~ready_o;
    assign accept   = mem_valid_i & ready_o & ~flush_i;
    assign off      = mem_addr_i[1:0];
    assign size_eff = (mem_ll_i | mem_sc_i) ? 2'd2 : mem_size_i;
    assign ale      = ((size_eff == 2'd1) & off[0]) | (size_eff[1] & (off != 2'b00));
    assign go_bus   = accept & ~ale & ~sc_fail;
    // ALE and SC-fail complete locally the next cycle without touching the bus
    assign fast     = accept & (ale | sc_fail);
    assign data_ok  = bus.data_data_ok_i;
    assign timeout  = (TIMEOUT_CYCLES != 0) && (state != IDLE) && (cnt == TO_LAST);

`ifdef MEM_LLSC_EN
    logic llbit;
    assign sc_fail = mem_sc_i & ~llbit;

    // Clear request wins over an LL completing in the same cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            llbit <= 1'b0;
        else if (llbit_clr_i)
            llbit <= 1'b0;
        else if (state == WAIT && data_ok && !flush_i) begin
            if (op.ll)
                llbit <= 1'b1;
            else if (op.sc)
                llbit <= 1'b0;
        end
    end
`else
    logic unused_llsc;
    assign sc_fail     = 1'b0;
    assign unused_llsc = llbit_clr_i ^ op.ll;
`endif

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    // Next state. A watchdog expiry beats addr_ok in REQ, but a real data_ok
    // in WAIT beats the watchdog.
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:  if (go_bus) state_nxt = REQ;
            REQ: begin
                if (timeout)                 state_nxt = IDLE;
                else if (bus.data_addr_ok_i) state_nxt = flush_i ? DRAIN : WAIT;
                else if (flush_i)            state_nxt = IDLE;
            end
            WAIT: begin
                if (data_ok || timeout)      state_nxt = IDLE;
                else if (flush_i)            state_nxt = DRAIN;
            end
            DRAIN: if (data_ok || timeout) state_nxt = IDLE;
        endcase
    end

    // Lane steering for the op being accepted
    always_comb begin
        unique case (size_eff)
            2'd0: begin
                strb_d  = 4'b1000 >> off;
                wdata_d = {4{store_data_i[7:0]}};
            end
            2'd1: begin
                strb_d  = off[1] ? 4'b0011 : 4'b1100;
                wdata_d = {2{store_data_i[15:0]}};
            end
            default: begin
                strb_d  = 4'b1111;
                wdata_d = store_data_i;
            end
        endcase
    end

    // Load extraction from the latched op; offset 0 lives in the top byte
    always_comb begin
        unique case (op.addr[1:0])
            2'd0:    byte_v = bus.data_rdata_i[31:24];
            2'd1:    byte_v = bus.data_rdata_i[23:16];
            2'd2:    byte_v = bus.data_rdata_i[15:8];
            default: byte_v = bus.data_rdata_i[7:0];
        endcase
        half_v = op.addr[1] ? bus.data_rdata_i[15:0] : bus.data_rdata_i[31:16];
        unique case (op.size)
            2'd0:    load_val = op.uns ? {24'd0, byte_v} : {{24{byte_v[7]}}, byte_v};
            2'd1:    load_val = op.uns ? {16'd0, half_v} : {{16{half_v[15]}}, half_v};
            default: load_val = bus.data_rdata_i;
        endcase
    end

    // Completion outputs (next-cycle values)
    always_comb begin
        done_d   = 1'b0;
        ale_d    = 1'b0;
        buserr_d = 1'b0;
        fast_d   = 1'b0;
        rdata_d  = '0;
        tag_d    = op.tag;
        bad_d    = '0;
        if (fast) begin
            done_d = 1'b1;
            fast_d = 1'b1;
            ale_d  = ale;
            bad_d  = ale ? mem_addr_i : '0;
            tag_d  = tag_i;
        end else if (state == WAIT && data_ok && !flush_i) begin
            done_d  = 1'b1;
            rdata_d = op.sc ? 32'd1 : (op.we ? 32'd0 : load_val);
        end else if ((state == REQ || (state == WAIT && !data_ok)) && timeout && !flush_i) begin
            done_d   = 1'b1;
            buserr_d = 1'b1;
            bad_d    = op.addr;
        end
    end

    // Datapath, bus and completion registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op                <= '0;
            cnt               <= '0;
            bus.data_req_o    <= 1'b0;
            bus.data_wr_o     <= 1'b0;
            bus.data_wstrb_o  <= '0;
            bus.data_addr_o   <= '0;
            bus.data_wdata_o  <= '0;
            done_q            <= 1'b0;
            ale_q             <= 1'b0;
            fast_q            <= 1'b0;
            buserr_o          <= 1'b0;
            rdata_o           <= '0;
            tag_o             <= '0;
            bad_addr_o        <= '0;
        end else begin
            cnt <= (state == IDLE) ? '0 : cnt + 1'b1;
            if (accept) begin
                op.we   <= mem_we_i | mem_sc_i;
                op.size <= size_eff;
                op.uns  <= mem_unsigned_i;
                op.ll   <= mem_ll_i;
                op.sc   <= mem_sc_i;
                op.addr <= mem_addr_i;
                op.tag  <= tag_i;
            end
            // Request stays up, with stable fields, for as long as we sit in REQ
            bus.data_req_o <= (state_nxt == REQ);
            if (go_bus) begin
                bus.data_wr_o    <= mem_we_i | mem_sc_i;
                bus.data_wstrb_o <= strb_d;
                bus.data_addr_o  <= {mem_addr_i[ADDR_WIDTH-1:2], 2'b00};
                bus.data_wdata_o <= wdata_d;
            end
            done_q     <= done_d;
            ale_q      <= ale_d;
            fast_q     <= fast_d;
            buserr_o   <= buserr_d;
            rdata_o    <= rdata_d;
            tag_o      <= tag_d;
            bad_addr_o <= bad_d;
        end
    end

    // A flush arriving while an ALE/SC-fail result is on the outputs kills it
    assign kill   = fast_q & flush_i;
    assign done_o = done_q & ~kill;
    assign ale_o  = ale_q & ~kill;
endmodule

// File: tb/tb_mem_access_unit.sv
module tb_mem_access_unit;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic        mem_valid, valid_b, we, uns, ll, sc, flush, llclr;
    logic [1:0]  size;
    logic [31:0] addr, wdata;
    logic [4:0]  tag;

    logic        ready, done, ale, buserr, busy;
    logic [31:0] rdata, bad;
    logic [4:0]  tag_out;
    logic        ready_b, done_b, ale_b, buserr_b, busy_b;
    logic [31:0] rdata_b, bad_b;
    logic [4:0]  tag_out_b;

    mem_access_unit_if #(.ADDR_WIDTH(32)) bus ();
    mem_access_unit_if #(.ADDR_WIDTH(32)) bus_b ();

    mem_access_unit #(.ADDR_WIDTH(32), .TAG_WIDTH(5), .TIMEOUT_CYCLES(255)) dut (
        .clk(clk), .rst(rst), .mem_valid_i(mem_valid), .ready_o(ready),
        .mem_we_i(we), .mem_size_i(size), .mem_unsigned_i(uns), .mem_ll_i(ll),
        .mem_sc_i(sc), .mem_addr_i(addr), .store_data_i(wdata), .tag_i(tag),
        .flush_i(flush), .llbit_clr_i(llclr), .done_o(done), .rdata_o(rdata),
        .tag_o(tag_out), .ale_o(ale), .buserr_o(buserr), .bad_addr_o(bad),
        .busy_o(busy), .bus(bus)
    );

    mem_access_unit #(.ADDR_WIDTH(32), .TAG_WIDTH(5), .TIMEOUT_CYCLES(4)) dut_b (
        .clk(clk), .rst(rst), .mem_valid_i(valid_b), .ready_o(ready_b),
        .mem_we_i(we), .mem_size_i(size), .mem_unsigned_i(uns), .mem_ll_i(ll),
        .mem_sc_i(sc), .mem_addr_i(addr), .store_data_i(wdata), .tag_i(tag),
        .flush_i(flush), .llbit_clr_i(llclr), .done_o(done_b), .rdata_o(rdata_b),
        .tag_o(tag_out_b), .ale_o(ale_b), .buserr_o(buserr_b), .bad_addr_o(bad_b),
        .busy_o(busy_b), .bus(bus_b)
    );

    typedef struct packed {
        logic [31:0] rdata;
        logic [4:0]  tag;
        logic        ale;
        logic        buserr;
        logic [31:0] bad;
    } cmp_t;

    cmp_t exp_q[$];
    int   n_chk  = 0;
    int   n_pass = 0;

    // Scoreboard: every completion pulse must match the oldest expectation
    always @(negedge clk) begin
        if (!rst && done) begin
            n_chk++;
            if (exp_q.size() == 0)
                $display("FAIL unexpected_done: tag %0d rdata %h, no completion expected", tag_out, rdata);
            else begin
                cmp_t e;
                cmp_t g;
                e = exp_q.pop_front();
                g = {rdata, tag_out, ale, buserr, bad};
                if (g !== e)
                    $display("FAIL completion: got %h want %h", g, e);
                else
                    n_pass++;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: bench did not finish");
        $fatal(1, "bench stopped");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic w, input logic [1:0] sz, input logic u, input logic l,
                        input logic s, input logic [31:0] a, input logic [31:0] d, input logic [4:0] t);
        we = w; size = sz; uns = u; ll = l; sc = s; addr = a; wdata = d; tag = t;
        mem_valid = 1'b1;
        step();
        mem_valid = 1'b0;
    endtask

    // Full bus transaction with addr_ok held off for dly cycles, zero-wait data
    task automatic run_access(input string nm, input logic w, input logic [1:0] sz, input logic u,
                              input logic l, input logic s, input logic [31:0] a, input logic [31:0] d,
                              input logic [4:0] t, input logic [31:0] rd, input logic [3:0] strb,
                              input logic [31:0] wd, input logic [31:0] res, input int dly);
        logic [69:0] want;
        want = {1'b1, w | s, strb, a[31:2], 2'b00, wd};
        exp_q.push_back({res, t, 1'b0, 1'b0, 32'h0});
        send(w, sz, u, l, s, a, d, t);
        for (int i = 0; i < dly; i++) begin
            @(negedge clk);
            n_chk++;
            if ({bus.data_req_o, bus.data_wr_o, bus.data_wstrb_o, bus.data_addr_o, bus.data_wdata_o, ready} !== {want, 1'b0})
                $display("FAIL %s_stall: bus %h want %h ready %b", nm,
                         {bus.data_req_o, bus.data_wr_o, bus.data_wstrb_o, bus.data_addr_o, bus.data_wdata_o}, want, ready);
            else n_pass++;
            step();
        end
        bus.data_addr_ok_i = 1'b1;
        @(negedge clk);
        n_chk++;
        if ({bus.data_req_o, bus.data_wr_o, bus.data_wstrb_o, bus.data_addr_o, bus.data_wdata_o} !== want)
            $display("FAIL %s_bus: got %h want %h", nm,
                     {bus.data_req_o, bus.data_wr_o, bus.data_wstrb_o, bus.data_addr_o, bus.data_wdata_o}, want);
        else n_pass++;
        step();
        bus.data_addr_ok_i = 1'b0;
        bus.data_data_ok_i = 1'b1;
        bus.data_rdata_i   = rd;
        step();
        bus.data_data_ok_i = 1'b0;
        @(negedge clk);
        n_chk++;
        if ({done, ready, bus.data_req_o} !== 3'b110)
            $display("FAIL %s_latency: done/ready/req %b want 110", nm, {done, ready, bus.data_req_o});
        else n_pass++;
    endtask

    // Op that completes locally (ALE or SC-fail): no request, done next cycle
    task automatic fast_op(input string nm, input logic w, input logic [1:0] sz, input logic s,
                           input logic [31:0] a, input logic [4:0] t, input logic is_ale);
        exp_q.push_back({32'h0, t, is_ale, 1'b0, is_ale ? a : 32'h0});
        send(w, sz, 1'b0, 1'b0, s, a, 32'h55, t);
        @(negedge clk);
        n_chk++;
        if ({done, bus.data_req_o, ready} !== 3'b101)
            $display("FAIL %s: done/req/ready %b want 101", nm, {done, bus.data_req_o, ready});
        else n_pass++;
    endtask

    task automatic test_reset();
        @(negedge clk);
        n_chk++;
        if ({ready, busy, done, ale, buserr, rdata, bad, tag_out} !== {1'b1, 1'b0, 3'b000, 32'h0, 32'h0, 5'h0})
            $display("FAIL reset_outputs: got %h", {ready, busy, done, ale, buserr, rdata, bad, tag_out});
        else n_pass++;
        n_chk++;
        if ({bus.data_req_o, bus.data_wr_o, bus.data_wstrb_o, bus.data_addr_o, bus.data_wdata_o} !== 70'h0)
            $display("FAIL reset_bus: got %h want 0",
                     {bus.data_req_o, bus.data_wr_o, bus.data_wstrb_o, bus.data_addr_o, bus.data_wdata_o});
        else n_pass++;
        step();
        rst = 1'b0;
        step();
    endtask

    task automatic test_loads();
        run_access("ld_b",  0, 2'd0, 0, 0, 0, 32'h1001, 0, 5'd3, 32'h12F35678, 4'b0100, 32'h0, 32'hFFFFFFF3, 0);
        run_access("ld_bu", 0, 2'd0, 1, 0, 0, 32'h1003, 0, 5'd4, 32'h12F356F8, 4'b0001, 32'h0, 32'h000000F8, 0);
        run_access("ld_h",  0, 2'd1, 0, 0, 0, 32'h1000, 0, 5'd5, 32'h87654321, 4'b1100, 32'h0, 32'hFFFF8765, 1);
        run_access("ld_hu", 0, 2'd1, 1, 0, 0, 32'h1002, 0, 5'd6, 32'h1234ABCD, 4'b0011, 32'h0, 32'h0000ABCD, 0);
        run_access("ld_w",  0, 2'd2, 0, 0, 0, 32'h1004, 0, 5'd7, 32'hDEADBEEF, 4'b1111, 32'h0, 32'hDEADBEEF, 0);
    endtask

    task automatic test_stores();
        run_access("st_h", 1, 2'd1, 0, 0, 0, 32'h1002, 32'h0000ABCD, 5'd8,  32'h0, 4'b0011, 32'hABCDABCD, 32'h0, 0);
        run_access("st_b", 1, 2'd0, 0, 0, 0, 32'h1000, 32'h0000005A, 5'd9,  32'h0, 4'b1000, 32'h5A5A5A5A, 32'h0, 2);
        run_access("st_w", 1, 2'd2, 0, 0, 0, 32'h1008, 32'hCAFEF00D, 5'd10, 32'h0, 4'b1111, 32'hCAFEF00D, 32'h0, 1);
    endtask

    task automatic test_ale();
        fast_op("ale_ldw", 0, 2'd2, 0, 32'h1002, 5'd11, 1'b1);
        // back to back: accepted in the cycle the previous done is shown
        fast_op("ale_ldh", 0, 2'd1, 0, 32'h1001, 5'd12, 1'b1);
        fast_op("ale_stw", 1, 2'd2, 0, 32'h1003, 5'd13, 1'b1);
    endtask

    task automatic test_llsc();
        run_access("ll",    0, 2'd2, 0, 1, 0, 32'h2000, 0, 5'd14, 32'h0BADF00D, 4'b1111, 32'h0, 32'h0BADF00D, 0);
        run_access("sc_ok", 1, 2'd2, 0, 0, 1, 32'h2000, 32'h11223344, 5'd15, 32'h0, 4'b1111, 32'h11223344, 32'h1, 0);
        run_access("ll2",   0, 2'd2, 0, 1, 0, 32'h2000, 0, 5'd16, 32'h00000042, 4'b1111, 32'h0, 32'h00000042, 0);
        llclr = 1'b1;
        step();
        llclr = 1'b0;
`ifdef MEM_LLSC_EN
        fast_op("sc_fail", 1, 2'd2, 1, 32'h2000, 5'd17, 1'b0);
`else
        run_access("sc_nollsc", 1, 2'd2, 0, 0, 1, 32'h2000, 32'h99887766, 5'd17, 32'h0, 4'b1111, 32'h99887766, 32'h1, 0);
`endif
    endtask

    task automatic test_flush();
        int wait_cnt;
        // flush in REQ, no addr_ok: request withdrawn, stray data_ok ignored
        send(0, 2'd2, 0, 0, 0, 32'h1100, 0, 5'd18);
        flush = 1'b1;
        step();
        flush = 1'b0;
        @(negedge clk);
        n_chk++;
        if ({bus.data_req_o, ready, done} !== 3'b010)
            $display("FAIL flush_req_drop: req/ready/done %b want 010", {bus.data_req_o, ready, done});
        else n_pass++;
        bus.data_data_ok_i = 1'b1;
        step();
        bus.data_data_ok_i = 1'b0;
        @(negedge clk);
        n_chk++;
        if ({done, ready} !== 2'b01)
            $display("FAIL stray_data_ok: done/ready %b want 01", {done, ready});
        else n_pass++;
        // flush in WAIT, data_ok arrives 5 cycles later
        send(0, 2'd2, 0, 0, 0, 32'h1104, 0, 5'd19);
        bus.data_addr_ok_i = 1'b1;
        step();
        bus.data_addr_ok_i = 1'b0;
        flush = 1'b1;
        step();
        flush = 1'b0;
        wait_cnt = 0;
        for (int i = 0; i < 5; i++) begin
            if (i == 4) bus.data_data_ok_i = 1'b1;
            @(negedge clk);
            if (!ready && busy) wait_cnt++;
            step();
        end
        bus.data_data_ok_i = 1'b0;
        n_chk++;
        if (wait_cnt !== 5)
            $display("FAIL drain_busy: busy cycles %0d want 5", wait_cnt);
        else n_pass++;
        @(negedge clk);
        n_chk++;
        if ({done, ready} !== 2'b01)
            $display("FAIL drain_exit: done/ready %b want 01", {done, ready});
        else n_pass++;
        // flush in IDLE blocks acceptance
        we = 0; size = 2'd2; ll = 0; sc = 0; addr = 32'h1108; tag = 5'd20;
        mem_valid = 1'b1;
        flush = 1'b1;
        step();
        mem_valid = 1'b0;
        flush = 1'b0;
        @(negedge clk);
        n_chk++;
        if ({bus.data_req_o, ready} !== 2'b01)
            $display("FAIL flush_idle_block: req/ready %b want 01", {bus.data_req_o, ready});
        else n_pass++;
        // flush suppresses a pending ALE completion
        send(0, 2'd2, 0, 0, 0, 32'h1006, 0, 5'd21);
        flush = 1'b1;
        @(negedge clk);
        n_chk++;
        if ({done, ale} !== 2'b00)
            $display("FAIL flush_ale: done/ale %b want 00", {done, ale});
        else n_pass++;
        step();
        flush = 1'b0;
        // flush in REQ together with addr_ok: drain then silent return
        send(0, 2'd2, 0, 0, 0, 32'h110C, 0, 5'd22);
        bus.data_addr_ok_i = 1'b1;
        flush = 1'b1;
        step();
        bus.data_addr_ok_i = 1'b0;
        flush = 1'b0;
        @(negedge clk);
        n_chk++;
        if ({ready, bus.data_req_o} !== 2'b00)
            $display("FAIL flush_req_aok: ready/req %b want 00", {ready, bus.data_req_o});
        else n_pass++;
        bus.data_data_ok_i = 1'b1;
        step();
        bus.data_data_ok_i = 1'b0;
        @(negedge clk);
        n_chk++;
        if ({done, ready} !== 2'b01)
            $display("FAIL drain_req_exit: done/ready %b want 01", {done, ready});
        else n_pass++;
    endtask

    task automatic test_reset_abort();
        send(0, 2'd2, 0, 0, 0, 32'h1200, 0, 5'd23);
        bus.data_addr_ok_i = 1'b1;
        step();
        bus.data_addr_ok_i = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        n_chk++;
        if ({ready, busy, bus.data_req_o} !== 3'b100)
            $display("FAIL reset_abort: ready/busy/req %b want 100", {ready, busy, bus.data_req_o});
        else n_pass++;
        step();
        rst = 1'b0;
        bus.data_data_ok_i = 1'b1;
        step();
        bus.data_data_ok_i = 1'b0;
        @(negedge clk);
        n_chk++;
        if ({done, ready} !== 2'b01)
            $display("FAIL late_response: done/ready %b want 01", {done, ready});
        else n_pass++;
        step();
    endtask

    task automatic test_timeout();
        int req_cycles;
        int seen;
        we = 0; size = 2'd2; uns = 0; ll = 0; sc = 0; addr = 32'h3000; wdata = 0; tag = 5'd7;
        valid_b = 1'b1;
        step();
        valid_b = 1'b0;
        req_cycles = 0;
        seen = 0;
        for (int i = 1; i <= 12 && seen == 0; i++) begin
            @(negedge clk);
            if (done_b) seen = i;
            else begin
                if (bus_b.data_req_o) req_cycles++;
                step();
            end
        end
        n_chk++;
        if (seen !== 5 || req_cycles !== 4)
            $display("FAIL timeout_latency: done at %0d (want 5), req cycles %0d (want 4)", seen, req_cycles);
        else n_pass++;
        n_chk++;
        if ({buserr_b, ale_b, bad_b, tag_out_b, rdata_b, ready_b} !== {1'b1, 1'b0, 32'h3000, 5'd7, 32'h0, 1'b1})
            $display("FAIL timeout_payload: got %h want %h", {buserr_b, ale_b, bad_b, tag_out_b, rdata_b, ready_b},
                     {1'b1, 1'b0, 32'h3000, 5'd7, 32'h0, 1'b1});
        else n_pass++;
        step();
        @(negedge clk);
        n_chk++;
        if ({done_b, buserr_b, ready_b} !== 3'b001)
            $display("FAIL timeout_pulse: done/buserr/ready %b want 001", {done_b, buserr_b, ready_b});
        else n_pass++;
    endtask

    initial begin
        mem_valid = 0; valid_b = 0; we = 0; uns = 0; ll = 0; sc = 0; flush = 0; llclr = 0;
        size = 0; addr = 0; wdata = 0; tag = 0;
        bus.data_addr_ok_i = 0; bus.data_data_ok_i = 0; bus.data_rdata_i = 0;
        bus_b.data_addr_ok_i = 0; bus_b.data_data_ok_i = 0; bus_b.data_rdata_i = 0;
        test_reset();
        test_loads();
        test_stores();
        test_ale();
        test_llsc();
        test_flush();
        test_reset_abort();
        test_timeout();
        repeat (3) step();
        n_chk++;
        if (exp_q.size() != 0)
            $display("FAIL missing_done: %0d completions never seen", exp_q.size());
        else n_pass++;
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

Multi-cycle load/store unit for the memory stage of the LoongArch pipeline. It replaces the single-cycle, combinational data-RAM access with a handshaked request/response bus (`req`/`addr_ok`/`data_ok`) so it can sit in front of a data cache or an AXI bridge. It performs:
- byte-lane steering and sign/zero extension;
- ALE detection;
- LL/SC with an internal LLbit;
- pipeline flush handling;
- a bus-timeout watchdog.

## Interface
Parameters:
- `ADDR_WIDTH`, 32, width of the address path.
- `TAG_WIDTH`, 5, width of the destination tag carried from request to response.
- `TIMEOUT_CYCLES`, 255, bus-wait limit in cycles. 0 disables the watchdog.

Ports:
- `clk` in 1: clock.
- `rst` in 1: reset, asynchronous, active-high.
- `mem_valid_i` in 1: an op is presented.
- `ready_o` out 1: the unit can accept an op (state IDLE).
- `mem_we_i` in 1: 1 = store.
- `mem_size_i` in 2: 0 = byte, 1 = half, 2 = word.
- `mem_unsigned_i` in 1: zero-extend loads.
- `mem_ll_i` in 1: LL.W.
- `mem_sc_i` in 1: SC.W.
- `mem_addr_i` in ADDR_WIDTH: byte address.
- `store_data_i` in 32: store data.
- `tag_i` in TAG_WIDTH: destination register tag.
- `flush_i` in 1: pipeline flush.
- `llbit_clr_i` in 1: clear LLbit (ERTN).
- `done_o` out 1: one-cycle completion pulse.
- `rdata_o` out 32: load result, or SC result.
- `tag_o` out TAG_WIDTH: tag of the completed op.
- `ale_o` out 1: misaligned-address exception.
- `buserr_o` out 1: watchdog expired.
- `bad_addr_o` out ADDR_WIDTH: faulting address.
- `busy_o` out 1: state is not IDLE.
- `data_req_o` out 1: bus request.
- `data_wr_o` out 1: bus write.
- `data_wstrb_o` out 4: byte strobe.
- `data_addr_o` out ADDR_WIDTH: bus address, word-aligned.
- `data_wdata_o` out 32: bus write data.
- `data_addr_ok_i` in 1: request accepted.
- `data_data_ok_i` in 1: response or write acknowledge.
- `data_rdata_i` in 32: bus read data.

## Operation
- States: IDLE, REQ, WAIT, DRAIN.
- Accept condition: `mem_valid_i & ready_o & !flush_i`. On accept, the unit latches the op, address, data and tag.
- Lane convention: byte offset 0 maps to bits [31:24] and strobe bit 3; offset 3 maps to [7:0] and strobe bit 0.
- Strobes:
  - Byte: one-hot on the offset.
  - Half: `1100` at offset 0, `0011` at offset 2.
  - Word: `1111`.
- Store data replication:
  - Byte: `{4{d[7:0]}}`.
  - Half: `{2{d[15:0]}}`.
  - Word: `d`.
- Loads: the selected lane is sign-extended, or zero-extended when `mem_unsigned_i` is set.
- ALE: a half at an odd offset, or a word at a nonzero offset, raises ALE. The op issues no bus request and stays in IDLE. The next cycle `done_o=1`, `ale_o=1`, `bad_addr_o` = the address, `rdata_o=0`.
- Successful access path: IDLE → REQ on accept; REQ → WAIT on `data_addr_ok_i`; WAIT → IDLE on `data_data_ok_i`. `done_o` pulses the cycle after `data_ok`.
- LL: completes as a word load and sets LLbit at completion.
- SC when LLbit = 1: performs a word store, `rdata_o=1`, and clears LLbit at completion.
- SC when LLbit = 0: issues no bus request; `done_o` next cycle with `rdata_o=0`.
- `llbit_clr_i` clears LLbit. If it coincides with an LL completion, the clear wins.
- Flush:
  - In IDLE: blocks acceptance; a pending ALE or SC-fail completion is suppressed.
  - In REQ without `addr_ok` in the same cycle: `data_req_o` drops and the state goes to IDLE next cycle; no `done_o`.
  - In REQ with `addr_ok`, or in WAIT: the state goes to DRAIN; the unit waits for `data_ok`, then returns to IDLE with no `done_o` and no LLbit update.
- Watchdog: a counter clears on entering REQ and increments in REQ and WAIT. When it reaches `TIMEOUT_CYCLES`, the unit returns to IDLE, `done_o=1`, `buserr_o=1`, and `bad_addr_o` = the address. In DRAIN, timeout returns to IDLE silently.

## Timing
- Reset values: every output 0, state IDLE, LLbit 0. Exception: `ready_o=1` (combinational on IDLE).
- All bus outputs are registered.
- Minimum load/store latency: accept at N; `req` high at N+1; `addr_ok` at N+1; `data_ok` at N+2; `done_o` at N+3.
- `data_req_o`, `data_addr_o`, `data_wr_o`, `data_wstrb_o` and `data_wdata_o` are held stable in REQ until `addr_ok`.
- `data_data_ok_i` is honoured only in WAIT or DRAIN and ignored elsewhere.
- An ALE or SC-fail completion occurs at N+1.
- `ready_o` is low from N+1 until the cycle after return to IDLE. A new accept is possible in the same cycle that `done_o` is high.
- `rst` mid-transaction aborts immediately to IDLE. A bus response arriving after reset is ignored.

## Configuration
- `MEM_LLSC_EN` defined: LLbit, the SC-fail path and `llbit_clr_i` logic are present.
- `MEM_LLSC_EN` undefined:
  - LL behaves as a plain word load.
  - SC always stores and returns `rdata_o=1`.
  - `llbit_clr_i` is ignored.

## Test plan
- LD.B signed at `0x1001`, `data_rdata_i=0x12F35678` → `data_wstrb_o=0100`, `rdata_o=0xFFFFFFF3`, `done_o` 3 cycles after accept with zero-wait bus.
- ST.H at `0x1002`, `store_data_i=0x0000ABCD` → `data_wstrb_o=0011`, `data_wdata_o=0xABCDABCD`, `data_wr_o=1`, `data_addr_o=0x1000`.
- LD.W at `0x1002` → no `data_req_o`; next cycle `done_o=1`, `ale_o=1`, `bad_addr_o=0x1002`.
- LL.W at `0x2000`, then SC.W at `0x2000` → `rdata_o=1` and a store issued. LL.W, `llbit_clr_i`, then SC.W → `rdata_o=0` and no request.
- `flush_i` in REQ with `addr_ok` low → `req` drops and no `done_o`. `flush_i` in WAIT, then `data_ok` 5 cycles later → no `done_o` and `ready_o` returns.
- `TIMEOUT_CYCLES=4`, `addr_ok` never asserted → `done_o` and `buserr_o` after 4 REQ cycles; state IDLE.
